snr_display_driver: RTL and testbench

// Downstream consumer of the SNR estimator. Takes the signed integer-dB SNR stream and shows it
// on four active-low 7-segment digits as sign plus three decimal digits.

---
 rtl/snr_display_driver.sv | 143 ++++++++++++++
 tb/tb_snr_display_driver.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/snr_display_driver.sv
// Shows a signed integer-dB SNR stream as sign plus three decimal digits on active-low 7-segment displays.
// The display refreshes at UPDATE_HZ with a decaying peak-hold; binary-to-BCD uses an iterative double-dabble.
module snr_display_driver #(
  parameter int SNR_WIDTH       = 8,
  parameter int CLK_HZ          = 50_000_000,
  parameter int UPDATE_HZ       = 10,
  parameter int PEAK_HOLD_TICKS = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [SNR_WIDTH-1:0] snr_db,
  input  logic                        snr_valid,
  output logic                        snr_ready,
  output logic [6:0]                  hex0,
  output logic [6:0]                  hex1,
  output logic [6:0]                  hex2,
  output logic [6:0]                  hex3,
  output logic                        display_valid
);

  localparam int PERIOD = CLK_HZ / UPDATE_HZ;
  localparam int TCNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int HOLD_W = (PEAK_HOLD_TICKS > 0) ? $clog2(PEAK_HOLD_TICKS + 1) : 1;
  localparam int SCNT_W = $clog2(SNR_WIDTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e                      state_q;
  logic [TCNT_W-1:0]           tcnt_q;
  logic                        tick;
  logic signed [SNR_WIDTH-1:0] latest_q, peak_q, peak_d;
  logic [HOLD_W-1:0]           hold_q, hold_d;
  logic                        neg_q;
  logic [SNR_WIDTH-1:0]        mag_q;
  logic [11:0]                 bcd_q, bcd_adj;
  logic [11+SNR_WIDTH:0]       shift_d;
  logic [SCNT_W-1:0]           scnt_q;
  logic [6:0]                  hex0_q, hex1_q, hex2_q, hex3_q;
  logic                        dv_q;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign tick = (tcnt_q == TCNT_W'(PERIOD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     tcnt_q <= '0;
    else if (tick) tcnt_q <= '0;
    else           tcnt_q <= tcnt_q + 1'b1;
  end

  // Signed compare: a new peak (or an expired hold) takes over and restarts the hold.
  always_comb begin
    peak_d = peak_q;
    hold_d = hold_q;
    if (latest_q >= peak_q || hold_q == '0) begin
      peak_d = latest_q;
      hold_d = HOLD_W'(PEAK_HOLD_TICKS);
    end else begin
      hold_d = hold_q - 1'b1;
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shift_d = {bcd_adj, mag_q} << 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      latest_q <= '0;
      peak_q   <= '0;
      hold_q   <= '0;
      neg_q    <= 1'b0;
      mag_q    <= '0;
      bcd_q    <= '0;
      scnt_q   <= '0;
      hex0_q   <= 7'h7F;
      hex1_q   <= 7'h7F;
      hex2_q   <= 7'h7F;
      hex3_q   <= 7'h7F;
      dv_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (snr_valid) latest_q <= snr_db;
          if (tick) begin
            peak_q  <= peak_d;
            hold_q  <= hold_d;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          // Negating the most negative value wraps to 2^(W-1), which is the correct unsigned magnitude.
          neg_q   <= peak_q[SNR_WIDTH-1];
          mag_q   <= peak_q[SNR_WIDTH-1] ? $unsigned(-peak_q) : $unsigned(peak_q);
          bcd_q   <= '0;
          scnt_q  <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          {bcd_q, mag_q} <= shift_d;
          if (scnt_q == SCNT_W'(SNR_WIDTH - 1)) state_q <= DONE;
          else                                   scnt_q  <= scnt_q + 1'b1;
        end
        DONE: begin
          hex0_q  <= seg7(bcd_q[3:0]);
          hex1_q  <= (bcd_q[11:8] == 4'd0 && bcd_q[7:4] == 4'd0) ? 7'h7F : seg7(bcd_q[7:4]);
          hex2_q  <= (bcd_q[11:8] == 4'd0) ? 7'h7F : seg7(bcd_q[11:8]);
          hex3_q  <= neg_q ? 7'b0111111 : 7'h7F;
          dv_q    <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign snr_ready     = (state_q == IDLE);
  assign hex0          = hex0_q;
  assign hex1          = hex1_q;
  assign hex2          = hex2_q;
  assign hex3          = hex3_q;
  assign display_valid = dv_q;

endmodule

// File: tb/tb_snr_display_driver.sv
// Directed bench for snr_display_driver: one instance without peak-hold, one with a 3-tick hold.
// PERIOD=12 so each conversion (tick + 10 cycles) is back in IDLE before the next tick.
module tb_snr_display_driver;

  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] MN = 7'b0111111;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [7:0] db, dbh;
  logic              vld, vldh;
  logic              rdy, rdyh, dv, dvh;
  logic [6:0]        h0, h1, h2, h3, g0, g1, g2, g3;

  int n;
  int vec  = 0;
  int errs = 0;

  snr_display_driver #(
    .SNR_WIDTH(8), .CLK_HZ(120), .UPDATE_HZ(10), .PEAK_HOLD_TICKS(0)
  ) dut (
    .clk(clk), .reset(reset), .snr_db(db), .snr_valid(vld), .snr_ready(rdy),
    .hex0(h0), .hex1(h1), .hex2(h2), .hex3(h3), .display_valid(dv)
  );

  snr_display_driver #(
    .SNR_WIDTH(8), .CLK_HZ(120), .UPDATE_HZ(10), .PEAK_HOLD_TICKS(3)
  ) dut_h (
    .clk(clk), .reset(reset), .snr_db(dbh), .snr_valid(vldh), .snr_ready(rdyh),
    .hex0(g0), .hex1(g1), .hex2(g2), .hex3(g3), .display_valid(dvh)
  );

  always #5 clk = ~clk;

  // n = number of rising edges since reset release; ticks fire on edges 11, 23, 35, ...
  always @(posedge clk or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic disp(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                      input logic [6:0] e1, input logic [6:0] e0, input logic edv);
    check(tag, {4'h0, h3, h2, h1, h0}, {4'h0, e3, e2, e1, e0});
    check({tag, "_dv"}, {31'd0, dv}, {31'd0, edv});
  endtask

  task automatic disph(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                       input logic [6:0] e1, input logic [6:0] e0);
    check(tag, {4'h0, g3, g2, g1, g0}, {4'h0, e3, e2, e1, e0});
    check({tag, "_dv"}, {31'd0, dvh}, 32'd1);
  endtask

  task automatic goto(input int k);
    while (n < k) @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; vld = 1'b0; db = '0; vldh = 1'b0; dbh = '0;
    #2;
    disp("reset_state", BL, BL, BL, BL, 1'b0);
    check("reset_ready", {31'd0, rdy}, 32'd1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    goto(5);  disp("idle_no_done", BL, BL, BL, BL, 1'b0);
    goto(10); vldh = 1'b1; dbh = 8'sd40;
    goto(11); vldh = 1'b0;
    goto(21); disp("before_first_done", BL, BL, BL, BL, 1'b0);
    goto(22); disp("first_zero", BL, BL, BL, S0, 1'b1);
    disph("hold40_r1", BL, BL, S4, S0);
    vld = 1'b1; db = 8'sd23; vldh = 1'b1; dbh = 8'sd5;
    goto(23); vld = 1'b0; vldh = 1'b0;
    goto(27); check("ready_low_shift", {31'd0, rdy}, 32'd0);
    goto(33); disp("outputs_steady", BL, BL, BL, S0, 1'b1);
    goto(34); disp("show_23", BL, BL, S2, S3, 1'b1);
    disph("hold40_r2", BL, BL, S4, S0);
    vld = 1'b1; db = -8'sd128;
    goto(35); vld = 1'b0;
    goto(46); disp("show_m128", MN, S1, S2, S8, 1'b1);
    disph("hold40_r3", BL, BL, S4, S0);
    vld = 1'b1; db = 8'sd0;
    goto(47); vld = 1'b0;
    goto(58); disp("show_0", BL, BL, BL, S0, 1'b1);
    disph("hold40_r4", BL, BL, S4, S0);
    vld = 1'b1; db = -8'sd5;
    goto(59); vld = 1'b0;
    goto(70); disp("show_m5", MN, BL, BL, S5, 1'b1);
    disph("hold_expired_5", BL, BL, BL, S5);
    vld = 1'b1; db = 8'sd100; vldh = 1'b1; dbh = 8'sd60;
    goto(71); vld = 1'b0; vldh = 1'b0;
    goto(82); disp("show_100", BL, S1, S0, S0, 1'b1);
    disph("hold_new_60", BL, BL, S6, S0);
    vld = 1'b1; db = 8'sd127; vldh = 1'b1; dbh = 8'sd10;
    goto(83); vld = 1'b0; vldh = 1'b0;
    goto(94); disp("show_127", BL, S1, S2, S7, 1'b1);
    disph("hold_60_kept", BL, BL, S6, S0);
    vld = 1'b1; db = -8'sd90; vldh = 1'b1; dbh = 8'sd70;
    goto(95); vld = 1'b0; vldh = 1'b0;
    goto(106); disp("show_m90", MN, BL, S9, S0, 1'b1);
    disph("hold_rise_70", BL, BL, S7, S0);
    vld = 1'b1; db = 8'sd12;
    goto(107); db = 8'sd7;
    goto(108); vld = 1'b0;
    goto(118); disp("tick_uses_old", BL, BL, S1, S2, 1'b1);
    goto(121); vld = 1'b1; db = 8'sd99;
    goto(122); check("ready_low_busy", {31'd0, rdy}, 32'd0);
    goto(126); vld = 1'b0;
    goto(130); disp("next_shows_7", BL, BL, BL, S7, 1'b1);
    goto(142); disp("busy_not_taken", BL, BL, BL, S7, 1'b1);
    vld = 1'b1; db = 8'sd45;
    goto(143); vld = 1'b0;
    goto(148); reset = 1'b1;
    #1;
    disp("reset_abort", BL, BL, BL, BL, 1'b0);
    check("reset_abort_ready", {31'd0, rdy}, 32'd1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    goto(3);  vld = 1'b1; db = 8'sd81;
    goto(4);  vld = 1'b0;
    goto(21); disp("post_reset_blank", BL, BL, BL, BL, 1'b0);
    goto(22); disp("post_reset_81", BL, BL, S8, S1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
